// File: rtl/rpm_avg_pkg.sv
// rpm_avg_pkg: shared types and defaults for the crank tooth-period averager.
//   avg_state_e    : window state, FILL while fewer than DEPTH samples are held,
//                    RUN once the window is full.
//   sum_width_for  : minimum running-sum width for a given sample width/depth.
//   DEF_*          : default parameter values used by rpm_period_averager.
package rpm_avg_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } avg_state_e;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_DEPTH_LOG2   = 3;
  localparam int DEF_REJECT_LIMIT = 3;

  // A sum of 2^depth_log2 samples of input_width bits never needs more bits.
  function automatic int sum_width_for(input int input_width, input int depth_log2);
    return input_width + depth_log2;
  endfunction

endpackage

// File: rtl/rpm_avg_ring.sv
// rpm_avg_ring: DEPTH x INPUT_WIDTH ring storage for the period window.
// A single write port and a combinational read share one address, so the
// read returns the oldest sample that the current write is about to replace.
// The array has no reset; stale contents are ignored by the controller.
//   clk   in  : clock
//   we    in  : write enable
//   addr  in  : write / read address (ring write pointer)
//   wdata in  : sample to store
//   rdata out : current contents at addr (oldest sample)
module rpm_avg_ring #(
  parameter int INPUT_WIDTH = 16,
  parameter int DEPTH_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  addr,
  input  logic [INPUT_WIDTH-1:0] wdata,
  output logic [INPUT_WIDTH-1:0] rdata
);

  logic [INPUT_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/rpm_period_averager.sv
// rpm_period_averager: moving average of the last 2^DEPTH_LOG2 crank tooth
// periods, kept as an incremental running sum (add newest, subtract oldest).
// Optional feature macro: RPM_AVG_OUTLIER_REJECT_EN enables outlier rejection
// in RUN (sample > 2*avg or 2*sample < avg) with a resync after REJECT_LIMIT
// consecutive rejects. Without it every sample is accepted and reject is 0.
//   clk          in  : clock, all logic on posedge
//   reset        in  : asynchronous active-low reset
//   clear        in  : synchronous flush of window, sum and count (wins over a sample)
//   sample_valid in  : one-cycle strobe, sample accepted on this edge
//   sample       in  : tooth period in timer ticks
//   avg          out : sum >> DEPTH_LOG2, held between updates
//   avg_valid    out : one-cycle pulse after avg is updated from a full window
//   full         out : window holds DEPTH samples
//   fill_count   out : samples in window, 0..DEPTH
//   sum          out : running sum of the window
//   reject       out : one-cycle pulse when a sample is discarded
module rpm_period_averager
  import rpm_avg_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
  parameter int SUM_WIDTH    = sum_width_for(INPUT_WIDTH, DEPTH_LOG2),
  parameter int REJECT_LIMIT = DEF_REJECT_LIMIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   sample_valid,
  input  logic [INPUT_WIDTH-1:0] sample,
  output logic [INPUT_WIDTH-1:0] avg,
  output logic                   avg_valid,
  output logic                   full,
  output logic [DEPTH_LOG2:0]    fill_count,
  output logic [SUM_WIDTH-1:0]   sum,
  output logic                   reject
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LAST_FILL = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6 || SUM_WIDTH < INPUT_WIDTH + DEPTH_LOG2 ||
      REJECT_LIMIT < 1) begin : g_param_check
    $error("rpm_period_averager: illegal parameter combination");
  end

  function automatic logic [INPUT_WIDTH-1:0] avg_of(input logic [SUM_WIDTH-1:0] s);
    return INPUT_WIDTH'(s >> DEPTH_LOG2);
  endfunction

  avg_state_e             state_p1, state_nx;
  logic [DEPTH_LOG2-1:0]  wr_ptr_p1, wr_ptr_nx;
  logic [DEPTH_LOG2:0]    fill_p1, fill_nx;
  logic [SUM_WIDTH-1:0]   sum_p1, sum_nx;
  logic [INPUT_WIDTH-1:0] avg_p1, avg_nx;
  logic                   vld_p1, vld_nx;
  logic                   ring_we;
  logic [INPUT_WIDTH-1:0] oldest;
  logic                   take;
  logic                   flush;

`ifdef RPM_AVG_OUTLIER_REJECT_EN
  localparam int RC_W = $clog2(REJECT_LIMIT + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REJECT_LIMIT - 1);

  logic [RC_W-1:0] rej_cnt_p1, rej_cnt_nx;
  logic            rej_p1, rej_nx;
  logic            outlier;

  // Compared against the avg held before this edge; one extra bit avoids overflow of 2x.
  assign outlier = (state_p1 == RUN) &&
                   (({1'b0, sample} > {avg_p1, 1'b0}) || ({sample, 1'b0} < {1'b0, avg_p1}));
`endif

  rpm_avg_ring #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .DEPTH_LOG2  (DEPTH_LOG2)
  ) u_ring (
    .clk   (clk),
    .we    (ring_we),
    .addr  (wr_ptr_p1),
    .wdata (sample),
    .rdata (oldest)
  );

  always_comb begin
    state_nx  = state_p1;
    wr_ptr_nx = wr_ptr_p1;
    fill_nx   = fill_p1;
    sum_nx    = sum_p1;
    avg_nx    = avg_p1;
    vld_nx    = 1'b0;
    ring_we   = 1'b0;
    take      = sample_valid && !clear;
    flush     = clear;
`ifdef RPM_AVG_OUTLIER_REJECT_EN
    rej_nx     = 1'b0;
    rej_cnt_nx = rej_cnt_p1;
    if (clear) begin
      rej_cnt_nx = '0;
    end else if (take && outlier) begin
      take   = 1'b0;
      rej_nx = 1'b1;
      // The reject that reaches the limit resyncs the window.
      if (rej_cnt_p1 == RC_LAST) begin
        flush      = 1'b1;
        rej_cnt_nx = '0;
      end else begin
        rej_cnt_nx = rej_cnt_p1 + RC_W'(1);
      end
    end else if (take) begin
      rej_cnt_nx = '0;
    end
`endif
    if (flush) begin
      // Ring contents stay stale; fill_count tracks which entries are meaningful.
      sum_nx    = '0;
      fill_nx   = '0;
      wr_ptr_nx = '0;
      state_nx  = FILL;
    end else if (take) begin
      ring_we   = 1'b1;
      wr_ptr_nx = wr_ptr_p1 + DEPTH_LOG2'(1);
      if (state_p1 == FILL) begin
        sum_nx  = sum_p1 + SUM_WIDTH'(sample);
        fill_nx = fill_p1 + (DEPTH_LOG2 + 1)'(1);
        if (fill_p1 == LAST_FILL) begin
          state_nx = RUN;
          avg_nx   = avg_of(sum_nx);
          vld_nx   = 1'b1;
        end
      end else begin
        // oldest is part of sum_p1, so the subtraction cannot underflow.
        sum_nx = sum_p1 + SUM_WIDTH'(sample) - SUM_WIDTH'(oldest);
        avg_nx = avg_of(sum_nx);
        vld_nx = 1'b1;
      end
    end
  end

  // Stage p1: window state, sum/avg and the one-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1  <= FILL;
      wr_ptr_p1 <= '0;
      fill_p1   <= '0;
      sum_p1    <= '0;
      avg_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state_p1  <= state_nx;
      wr_ptr_p1 <= wr_ptr_nx;
      fill_p1   <= fill_nx;
      sum_p1    <= sum_nx;
      avg_p1    <= avg_nx;
      vld_p1    <= vld_nx;
    end
  end

`ifdef RPM_AVG_OUTLIER_REJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rej_cnt_p1 <= '0;
      rej_p1     <= 1'b0;
    end else begin
      rej_cnt_p1 <= rej_cnt_nx;
      rej_p1     <= rej_nx;
    end
  end

  assign reject = rej_p1;
`else
  assign reject = 1'b0;
`endif

  assign avg        = avg_p1;
  assign avg_valid  = vld_p1;
  assign full       = (state_p1 == RUN);
  assign fill_count = fill_p1;
  assign sum        = sum_p1;

endmodule

// File: tb/tb_rpm_period_averager.sv
// tb_rpm_period_averager: scoreboard bench for rpm_period_averager with DEPTH 4.
// The reference keeps the window as a queue of the last accepted samples; the
// sum is recomputed from that queue and the average is sum/DEPTH. Expected
// avg_valid / reject pulses are queued by the driver with the cycle they are
// due and checked by an independent monitor on the falling edge.
module tb_rpm_period_averager;

  localparam int IW    = 16;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int SW    = 18;
  localparam int RL    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clear = 1'b0;
  logic          sample_valid = 1'b0;
  logic [IW-1:0] sample = '0;
  logic [IW-1:0] avg;
  logic          avg_valid;
  logic          full;
  logic [DL:0]   fill_count;
  logic [SW-1:0] sum;
  logic          reject;

  always #5 clk = ~clk;

  rpm_period_averager #(
    .INPUT_WIDTH  (IW),
    .DEPTH_LOG2   (DL),
    .SUM_WIDTH    (SW),
    .REJECT_LIMIT (RL)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .clear        (clear),
    .sample_valid (sample_valid),
    .sample       (sample),
    .avg          (avg),
    .avg_valid    (avg_valid),
    .full         (full),
    .fill_count   (fill_count),
    .sum          (sum),
    .reject       (reject)
  );

  typedef struct {
    bit is_rej;
    int avg;
    int sum;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   win[$];
  int   avg_m = 0;
  int   rej_cnt_m = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  task automatic push_exp(input bit is_rej);
    exp_t e;
    e.is_rej = is_rej;
    e.avg    = avg_m;
    e.sum    = model_sum();
    e.due    = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic model_apply(input bit sv, input int s, input bit clr);
    if (clr) begin
      win.delete();
      rej_cnt_m = 0;
      return;
    end
    if (!sv) return;
`ifdef RPM_AVG_OUTLIER_REJECT_EN
    if (win.size() == DEPTH && (s > 2 * avg_m || 2 * s < avg_m)) begin
      rej_cnt_m++;
      if (rej_cnt_m == RL) begin
        win.delete();
        rej_cnt_m = 0;
      end
      push_exp(1'b1);
      return;
    end
    rej_cnt_m = 0;
`endif
    win.push_back(s);
    if (win.size() > DEPTH) void'(win.pop_front());
    if (win.size() == DEPTH) begin
      avg_m = model_sum() / DEPTH;
      push_exp(1'b0);
    end
  endtask

  task automatic model_reset();
    win.delete();
    exp_q.delete();
    avg_m = 0;
    rej_cnt_m = 0;
  endtask

  // One clock edge of stimulus followed by state checks just after the edge.
  task automatic step(input bit sv, input int s, input bit clr);
    sample_valid = sv;
    sample       = IW'(s);
    clear        = clr;
    model_apply(sv, s, clr);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    clear        = 1'b0;
    chk("sum", sum, model_sum());
    chk("fill_count", fill_count, win.size());
    chk("full", full, win.size() == DEPTH);
    chk("avg", avg, avg_m);
  endtask

  // Monitor: every pulse must match the head of the scoreboard on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("pulse_avg_valid", avg_valid, !e.is_rej);
        chk("pulse_reject", reject, e.is_rej);
        chk("pulse_avg", avg, e.avg);
        chk("pulse_sum", sum, e.sum);
      end else if (avg_valid || reject) begin
        chk("unexpected_pulse", {avg_valid, reject}, 0);
      end
    end
  end

  initial begin
    int r;
    int s;
    bit sv;
    bit clr;

    // Reset and check reset values.
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_avg", avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_fill_count", fill_count, 0);
    chk("rst_sum", sum, 0);
    chk("rst_reject", reject, 0);
    rst_n = 1'b1;

    // Fill with four 100s: one avg_valid after the fourth.
    for (int i = 0; i < 4; i++) step(1'b1, 100, 1'b0);
    chk("fill_sum400", sum, 400);
    chk("fill_avg100", avg, 100);
    step(1'b1, 200, 1'b0);
    chk("run_avg125", avg, 125);
    step(1'b1, 200, 1'b0);
    chk("run_avg150", avg, 150);
    chk("run_sum600", sum, 600);

    // Back-to-back samples cycling 1..7 across several pointer wraps.
    for (int i = 0; i < 20; i++) step(1'b1, (i % 7) + 1, 1'b0);

    // clear together with sample_valid while in RUN.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 50, 1'b0);
    step(1'b1, 77, 1'b1);
    chk("clr_sum", sum, 0);
    chk("clr_fill", fill_count, 0);
    chk("clr_full", full, 0);
    chk("clr_avg_held", avg, 50);

    // Randomised traffic: gaps, clears, occasional full-range periods.
    for (int i = 0; i < 300; i++) begin
      r   = $urandom_range(0, 99);
      sv  = (r < 75);
      clr = (r >= 97);
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 65535);
      else s = $urandom_range(80, 160);
      step(sv, s, clr);
    end

    // Asynchronous reset between edges while a pulse is in flight.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 120 + i, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_avg", avg, 0);
    chk("arst_avg_valid", avg_valid, 0);
    chk("arst_full", full, 0);
    chk("arst_fill_count", fill_count, 0);
    chk("arst_sum", sum, 0);
    chk("arst_reject", reject, 0);
    model_reset();
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 300 + 10 * i, 1'b0);

`ifdef RPM_AVG_OUTLIER_REJECT_EN
    // Outlier rejection and resync after three consecutive rejects.
    step(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 100, 1'b0);
    step(1'b1, 250, 1'b0);
    chk("rej_sum_held", sum, 400);
    step(1'b1, 250, 1'b0);
    step(1'b1, 250, 1'b0);
    chk("resync_fill", fill_count, 0);
    chk("resync_full", full, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 250, 1'b0);
    chk("resync_avg250", avg, 250);
`endif

    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rpm_period_averager.md
# rpm_period_averager

Parametrised moving-average filter for crank tooth periods, replacing the chain of fixed shift-register/adder stages in the RPM input path. It holds the last 2^DEPTH_LOG2 periods in a ring buffer and keeps an incremental running sum (add newest, subtract oldest). It emits the windowed average with a one-cycle valid pulse to the RPM/angle computation downstream.

## Interface
- INPUT_WIDTH, 16, tooth-period sample width (timer ticks)
- DEPTH_LOG2, 3, log2 of window depth (DEPTH = 8); legal range 1..6
- SUM_WIDTH, INPUT_WIDTH+DEPTH_LOG2, running-sum width; smaller values are illegal
- REJECT_LIMIT, 3, consecutive rejects that force a resync (used only with the macro)
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of window, sum and count
- sample_valid  in  1  one-cycle strobe; sample is accepted on this edge
- sample  in  INPUT_WIDTH  measured tooth period
- avg  out  INPUT_WIDTH  sum >> DEPTH_LOG2; held between updates
- avg_valid  out  1  one-cycle pulse; avg was updated from a full window
- full  out  1  window holds DEPTH samples
- fill_count  out  DEPTH_LOG2+1  samples in window, 0..DEPTH
- sum  out  SUM_WIDTH  current running sum
- reject  out  1  one-cycle pulse; sample discarded (tied 0 without the macro)

## Operation
- States: FILL (fill_count < DEPTH) and RUN (window full).
- FILL, accepted sample: write at wr_ptr; sum += sample; fill_count++; wr_ptr++. No avg_valid pulse. On reaching DEPTH -> RUN. The avg register updates on the same edge; avg_valid pulses one cycle later.
- RUN, accepted sample: oldest = ring[wr_ptr]; sum <= sum + sample - oldest; ring[wr_ptr] <= sample; wr_ptr++. avg <= new_sum >> DEPTH_LOG2; avg_valid pulses.
- wr_ptr is DEPTH_LOG2 bits wide and wraps naturally from DEPTH-1 to 0.
- Arithmetic is unsigned. SUM_WIDTH guarantees no overflow. The subtraction is never negative because oldest is contained in sum. avg truncates (floor).
- clear: ring contents are left stale but ignored; sum=0, fill_count=0, wr_ptr=0, state=FILL, avg holds, avg_valid=0.
- clear and sample_valid on the same edge: clear wins and the sample is dropped.
- A sample_valid strobe on every cycle is legal; there is no back-pressure.

## Timing
- Reset values: avg=0, avg_valid=0, full=0, fill_count=0, sum=0, reject=0, state FILL, wr_ptr=0, reject counter 0.
- Latency: sample edge N -> avg/sum/full registered at N. avg_valid and reject are asserted during the cycle after edge N (pulse generated at edge N, one cycle wide).
- Reset assertion mid-operation clears everything immediately, asynchronously. Deassertion is synchronised externally.

## Configuration
- RPM_AVG_OUTLIER_REJECT_EN defined: in RUN, a sample is rejected if sample > 2*avg or 2*sample < avg, comparing against the avg held before the edge.
  - A rejected sample is not written and does not change the sum.
  - reject pulses; avg_valid does not.
  - A consecutive-reject counter increments on each reject. Any accepted sample resets it to 0.
  - Reaching REJECT_LIMIT performs a clear (resync), so the next sample starts FILL.
  - No checks are made in FILL.
- Macro undefined: every sample is accepted, reject is tied to 0, and the counter logic is absent.

## Structure
- Package rpm_avg_pkg holds:
  - state enum {FILL, RUN}
  - a SUM_WIDTH helper function
  - the default parameter constants
- Sub-module rpm_avg_ring: DEPTH x INPUT_WIDTH storage with a single write port at wr_ptr and a combinational read of the same address (oldest). No reset on the storage array.

## Test plan
Use DEPTH_LOG2=2 (DEPTH 4) unless stated otherwise.
- Reset, then 4 samples of 100 -> fill_count goes 1..4, full rises after the 4th, sum=400, avg=100, exactly one avg_valid pulse (after the 4th).
- Full window of 100s, then samples 200, 200 -> sum 500 then 600, avg 125 then 150, avg_valid pulses on each.
- 20 back-to-back samples cycling 1..7 -> sum always equals a model sum of the last 4 samples; no wrap error at wr_ptr 3->0.
- clear asserted together with sample_valid while in RUN -> sample dropped, fill_count=0, sum=0, full=0, avg keeps its prior value.
- Reset asserted mid-stream between clock edges -> all outputs 0 immediately, before the next edge.
- With the macro, full window at avg 100: sample 250 -> reject pulse, sum unchanged. Then 250, 250 -> resync: fill_count=0, FILL, then 4 samples of 250 give avg 250.
